// File: rtl/enemy_walker.sv
// Patrolling ground enemy: walks a bounded path at a divided tick rate, turns at the
// patrol limit, playfield edge or wall, and can be stomped (squish, then dead) and respawned.
module enemy_walker #(
  parameter int X_START      = 280,
  parameter int Y_START      = 399,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int SIZE         = 16,
  parameter int STEP         = 1,
  parameter int PATROL_DIST  = 160,
  parameter int TICK_DIV     = 416667,
  parameter int TURN_PAUSE   = 8,
  parameter int SQUISH_TICKS = 30,
  parameter int SQUISH_YS    = 8,
  parameter int START_DIR    = 0
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       stomp,
  input  logic       wall_hit,
  input  logic       respawn,
  output logic [9:0] EnemyX,
  output logic [9:0] EnemyY,
  output logic [9:0] EnemyXS,
  output logic [9:0] EnemyYS,
  output logic       reverse,
  output logic       alive,
  output logic       squished
);

  typedef enum logic [1:0] {WALK, TURN, SQUISH, DEAD} state_t;

  // +2 keeps every counter at least one bit wide and able to hold its terminal count
  localparam int TW = $clog2(TICK_DIV + 2);
  localparam int DW = $clog2(PATROL_DIST + 2);
  localparam int PW = $clog2(TURN_PAUSE + 2);
  localparam int SW = $clog2(SQUISH_TICKS + 2);

  localparam logic [9:0]  X_RST   = 10'(X_START);
  localparam logic [9:0]  Y_RST   = 10'(Y_START);
  localparam logic [9:0]  Y_SQ    = 10'(Y_START + SIZE - SQUISH_YS);
  localparam logic [9:0]  SZ      = 10'(SIZE);
  localparam logic [9:0]  SQ_YS   = 10'(SQUISH_YS);
  localparam logic [9:0]  X_RMAX  = 10'(X_MAX - SIZE + 1);
  localparam logic [9:0]  X_LMIN  = 10'(X_MIN);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [10:0] R_LIM   = 11'(X_MAX - SIZE + 1);
  localparam logic [10:0] L_LIM   = 11'(X_MIN + STEP);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic        DIR_RST = (START_DIR != 0);

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]   dist_cnt_q, dist_cnt_d;
  logic [PW-1:0]   pause_cnt_q, pause_cnt_d;
  logic [SW-1:0]   squish_cnt_q, squish_cnt_d;
  logic [9:0]      x_q, x_d, y_q, y_d, xs_q, xs_d, ys_q, ys_d;
  logic            rev_q, rev_d, alive_q, alive_d, sq_q, sq_d;

  logic            tick, do_turn, edge_r, edge_l, patrol_done;
  logic [10:0]     x_ext;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    dist_cnt_d   = dist_cnt_q;
    pause_cnt_d  = pause_cnt_q;
    squish_cnt_d = squish_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    xs_d         = xs_q;
    ys_d         = ys_q;
    rev_d        = rev_q;
    alive_d      = alive_q;
    sq_d         = sq_q;
    do_turn      = 1'b0;

    tick  = enable && (int'(tick_cnt_q) == TICK_DIV - 1);
    if (enable) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // edge tests in 11 bits so X+STEP never wraps past the 10-bit range
    x_ext       = {1'b0, x_q};
    edge_r      = !rev_q && (x_ext + STEP11 > R_LIM);
    edge_l      = rev_q && (x_ext < L_LIM);
    patrol_done = (int'(dist_cnt_q) + 1 == PATROL_DIST);

    if (respawn) begin
      state_d      = WALK;
      tick_cnt_d   = '0;
      dist_cnt_d   = '0;
      pause_cnt_d  = '0;
      squish_cnt_d = '0;
      x_d          = X_RST;
      y_d          = Y_RST;
      xs_d         = SZ;
      ys_d         = SZ;
      rev_d        = DIR_RST;
      alive_d      = 1'b1;
      sq_d         = 1'b0;
    end else if (stomp && (state_q == WALK || state_q == TURN)) begin
      state_d      = SQUISH;
      ys_d         = SQ_YS;
      y_d          = Y_SQ;
      sq_d         = 1'b1;
      squish_cnt_d = '0;
    end else if (wall_hit && state_q == WALK) begin
      do_turn = 1'b1;
    end else if (tick) begin
      case (state_q)
        WALK: begin
          if (edge_r) begin
            x_d     = X_RMAX;
            do_turn = 1'b1;
          end else if (edge_l) begin
            x_d     = X_LMIN;
            do_turn = 1'b1;
          end else begin
            x_d        = rev_q ? x_q - STEP10 : x_q + STEP10;
            dist_cnt_d = dist_cnt_q + DW'(1);
            do_turn    = patrol_done;
          end
        end
        TURN: begin
          pause_cnt_d = pause_cnt_q + PW'(1);
          if (int'(pause_cnt_q) + 1 >= TURN_PAUSE) state_d = WALK;
        end
        SQUISH: begin
          squish_cnt_d = squish_cnt_q + SW'(1);
          if (int'(squish_cnt_q) + 1 >= SQUISH_TICKS) begin
            state_d = DEAD;
            sq_d    = 1'b0;
            alive_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (do_turn) begin
      rev_d       = !rev_q;
      dist_cnt_d  = '0;
      pause_cnt_d = '0;
      state_d     = (TURN_PAUSE == 0) ? WALK : TURN;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= WALK;
      tick_cnt_q   <= '0;
      dist_cnt_q   <= '0;
      pause_cnt_q  <= '0;
      squish_cnt_q <= '0;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      xs_q         <= SZ;
      ys_q         <= SZ;
      rev_q        <= DIR_RST;
      alive_q      <= 1'b1;
      sq_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      dist_cnt_q   <= dist_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      squish_cnt_q <= squish_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      rev_q        <= rev_d;
      alive_q      <= alive_d;
      sq_q         <= sq_d;
    end
  end

  assign EnemyX   = x_q;
  assign EnemyY   = y_q;
  assign EnemyXS  = xs_q;
  assign EnemyYS  = ys_q;
  assign reverse  = rev_q;
  assign alive    = alive_q;
  assign squished = sq_q;

endmodule

// File: tb/tb_enemy_walker.sv
// Bench for enemy_walker: directed scenarios plus random pulses against a behavioural model.
module tb_enemy_walker;
  localparam int TD = 4, PD = 4, TP = 2, SQT = 3;
  localparam int XS0 = 280, YS0 = 399, SZ = 16, SYS = 8, XMIN = 0, XMAX = 639, STP = 1;

  logic frame_clk = 0, Reset = 0, enable = 0, stomp = 0, wall_hit = 0, respawn = 0;
  logic [9:0] EnemyX, EnemyY, EnemyXS, EnemyYS;
  logic reverse, alive, squished;
  logic c_stomp = 0, c_wall = 0, c_resp = 0;
  logic [9:0] cX, cY, cXS, cYS;
  logic c_rev, c_alive, c_sq;

  int total = 0, bad = 0;

  always #5 frame_clk = ~frame_clk;

  enemy_walker #(.TICK_DIV(TD), .PATROL_DIST(PD), .TURN_PAUSE(TP), .SQUISH_TICKS(SQT)) u_dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .stomp(stomp), .wall_hit(wall_hit),
    .respawn(respawn), .EnemyX(EnemyX), .EnemyY(EnemyY), .EnemyXS(EnemyXS), .EnemyYS(EnemyYS),
    .reverse(reverse), .alive(alive), .squished(squished));

  enemy_walker #(.X_START(620), .TICK_DIV(TD), .PATROL_DIST(160), .TURN_PAUSE(TP),
                 .SQUISH_TICKS(SQT)) u_clamp (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .stomp(c_stomp), .wall_hit(c_wall),
    .respawn(c_resp), .EnemyX(cX), .EnemyY(cY), .EnemyXS(cXS), .EnemyYS(cYS),
    .reverse(c_rev), .alive(c_alive), .squished(c_sq));

  // behavioural model of the main instance
  localparam int PH_WALK = 0, PH_TURN = 1, PH_SQ = 2, PH_DEAD = 3;
  int m_x, m_y, m_ys, m_rev, m_alive, m_sq, m_ph, m_tick, m_walk, m_pause, m_squash;

  task automatic m_reset();
    m_x = XS0; m_y = YS0; m_ys = SZ; m_rev = 0; m_alive = 1; m_sq = 0;
    m_ph = PH_WALK; m_tick = 0; m_walk = 0; m_pause = 0; m_squash = 0;
  endtask

  task automatic m_turn();
    m_rev = 1 - m_rev; m_walk = 0; m_pause = 0;
    m_ph = (TP == 0) ? PH_WALK : PH_TURN;
  endtask

  task automatic m_step(input bit en, input bit st, input bit wh, input bit rs);
    bit tk;
    tk = en && (m_tick == TD - 1);
    if (en) m_tick = (m_tick + 1) % TD;
    if (rs) begin m_reset(); return; end
    if (st && (m_ph == PH_WALK || m_ph == PH_TURN)) begin
      m_ph = PH_SQ; m_ys = SYS; m_y = YS0 + SZ - SYS; m_sq = 1; m_squash = 0;
    end else if (wh && m_ph == PH_WALK) begin
      m_turn();
    end else if (tk) begin
      if (m_ph == PH_WALK) begin
        if (m_rev == 0 && m_x + STP > XMAX - SZ + 1) begin m_x = XMAX - SZ + 1; m_turn(); end
        else if (m_rev == 1 && m_x < XMIN + STP) begin m_x = XMIN; m_turn(); end
        else begin
          m_x = (m_rev == 1) ? m_x - STP : m_x + STP;
          m_walk++;
          if (m_walk == PD) m_turn();
        end
      end else if (m_ph == PH_TURN) begin
        m_pause++;
        if (m_pause == TP) m_ph = PH_WALK;
      end else if (m_ph == PH_SQ) begin
        m_squash++;
        if (m_squash == SQT) begin m_ph = PH_DEAD; m_sq = 0; m_alive = 0; end
      end
    end
  endtask

  task automatic step(input bit en, input bit st, input bit wh, input bit rs);
    enable = en; stomp = st; wall_hit = wh; respawn = rs;
    @(posedge frame_clk);
    m_step(en, st, wh, rs);
    #1;
    stomp = 0; wall_hit = 0; respawn = 0;
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    enable = 0; stomp = 0; wall_hit = 0; respawn = 0;
    Reset = 1;
    @(negedge frame_clk);
    Reset = 0;
    m_reset();
  endtask

  task automatic test_reset();
    @(negedge frame_clk);
    Reset = 1;
    #2;
    total++;
    if ({EnemyX, EnemyY, EnemyXS, EnemyYS, reverse, alive, squished} !==
        {10'd280, 10'd399, 10'd16, 10'd16, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_state: X=%0d Y=%0d XS=%0d YS=%0d rev=%b alive=%b sq=%b want 280 399 16 16 0 1 0",
                      EnemyX, EnemyY, EnemyXS, EnemyYS, reverse, alive, squished);
    end
    total++;
    if ({cX, c_rev} !== {10'd620, 1'b0}) begin
      bad++; $display("FAIL reset_clamp: X=%0d rev=%b want 620 0", cX, c_rev);
    end
    @(negedge frame_clk);
    Reset = 0;
    m_reset();
  endtask

  task automatic test_patrol();
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      step(1, 0, 0, 0);
      if (i == 16 || i == 24 || i == 27 || i == 28) begin
        int ex, er;
        ex = (i == 28) ? 283 : 284;
        er = 1;
        total++;
        if (EnemyX !== 10'(ex) || reverse !== 1'(er)) begin
          bad++; $display("FAIL patrol_step%0d: X=%0d rev=%b want %0d %0d", i, EnemyX, reverse, ex, er);
        end
      end
    end
  endtask

  task automatic test_clamp();
    int maxx;
    do_reset();
    maxx = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0, 0);
      if (int'(cX) > maxx) maxx = int'(cX);
      if (i == 16) begin
        total++;
        if (cX !== 10'd624 || c_rev !== 1'b0) begin
          bad++; $display("FAIL clamp_reach: X=%0d rev=%b want 624 0", cX, c_rev);
        end
      end
      if (i == 20) begin
        total++;
        if (cX !== 10'd624 || c_rev !== 1'b1) begin
          bad++; $display("FAIL clamp_turn: X=%0d rev=%b want 624 1", cX, c_rev);
        end
      end
      if (i == 32) begin
        total++;
        if (cX !== 10'd623 || c_rev !== 1'b1) begin
          bad++; $display("FAIL clamp_back: X=%0d rev=%b want 623 1", cX, c_rev);
        end
      end
    end
    total++;
    if (maxx != 624) begin
      bad++; $display("FAIL clamp_max: max X=%0d want 624", maxx);
    end
  endtask

  task automatic test_wall();
    do_reset();
    repeat (8) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    total++;
    if (EnemyX !== 10'd282 || reverse !== 1'b1) begin
      bad++; $display("FAIL wall_turn: X=%0d rev=%b want 282 1", EnemyX, reverse);
    end
    step(1, 0, 1, 0);
    total++;
    if (EnemyX !== 10'd282 || reverse !== 1'b1) begin
      bad++; $display("FAIL wall_in_turn: X=%0d rev=%b want 282 1", EnemyX, reverse);
    end
    for (int i = 11; i <= 32; i++) begin
      step(1, 0, 0, 0);
      if (i == 28) begin
        total++;
        if (EnemyX !== 10'd279 || reverse !== 1'b1) begin
          bad++; $display("FAIL wall_walk: X=%0d rev=%b want 279 1", EnemyX, reverse);
        end
      end
    end
    total++;
    if (EnemyX !== 10'd278 || reverse !== 1'b0) begin
      bad++; $display("FAIL wall_dist: X=%0d rev=%b want 278 0", EnemyX, reverse);
    end
  endtask

  task automatic test_stomp();
    do_reset();
    repeat (8) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    total++;
    if ({EnemyX, EnemyY, EnemyYS, squished, alive} !== {10'd282, 10'd407, 10'd8, 1'b1, 1'b1}) begin
      bad++; $display("FAIL stomp_squish: X=%0d Y=%0d YS=%0d sq=%b alive=%b want 282 407 8 1 1",
                      EnemyX, EnemyY, EnemyYS, squished, alive);
    end
    repeat (10) step(1, 0, 0, 0);
    total++;
    if (squished !== 1'b1 || alive !== 1'b1) begin
      bad++; $display("FAIL stomp_hold: sq=%b alive=%b want 1 1", squished, alive);
    end
    step(1, 0, 0, 0);
    total++;
    if (squished !== 1'b0 || alive !== 1'b0) begin
      bad++; $display("FAIL stomp_dead: sq=%b alive=%b want 0 0", squished, alive);
    end
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    repeat (8) step(1, 0, 0, 0);
    total++;
    if ({EnemyX, EnemyY, EnemyYS, reverse, alive, squished} !==
        {10'd282, 10'd407, 10'd8, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL dead_hold: X=%0d Y=%0d YS=%0d rev=%b alive=%b sq=%b want 282 407 8 0 0 0",
                      EnemyX, EnemyY, EnemyYS, reverse, alive, squished);
    end
  endtask

  task automatic test_respawn();
    step(1, 0, 0, 1);
    total++;
    if ({EnemyX, EnemyY, EnemyYS, reverse, alive, squished} !==
        {10'd280, 10'd399, 10'd16, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL respawn: X=%0d Y=%0d YS=%0d rev=%b alive=%b sq=%b want 280 399 16 0 1 0",
                      EnemyX, EnemyY, EnemyYS, reverse, alive, squished);
    end
    step(1, 1, 1, 0);
    total++;
    if (squished !== 1'b1 || reverse !== 1'b0 || EnemyYS !== 10'd8) begin
      bad++; $display("FAIL stomp_wall_same: sq=%b rev=%b YS=%0d want 1 0 8", squished, reverse, EnemyYS);
    end
  endtask

  task automatic test_enable();
    do_reset();
    repeat (6) step(1, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    total++;
    if (EnemyX !== 10'd281) begin
      bad++; $display("FAIL enable_freeze: X=%0d want 281", EnemyX);
    end
    step(1, 0, 0, 0);
    total++;
    if (EnemyX !== 10'd281) begin
      bad++; $display("FAIL enable_resume1: X=%0d want 281", EnemyX);
    end
    step(1, 0, 0, 0);
    total++;
    if (EnemyX !== 10'd282) begin
      bad++; $display("FAIL enable_resume2: X=%0d want 282", EnemyX);
    end
    step(1, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    #3 Reset = 1;
    #1;
    total++;
    if ({EnemyX, EnemyY, EnemyYS, reverse, alive, squished} !==
        {10'd280, 10'd399, 10'd16, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_mid_squish: X=%0d Y=%0d YS=%0d rev=%b alive=%b sq=%b want 280 399 16 0 1 0",
                      EnemyX, EnemyY, EnemyYS, reverse, alive, squished);
    end
    #1 Reset = 0;
    m_reset();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99) < 85, $urandom_range(99) < 3, $urandom_range(99) < 6,
           $urandom_range(199) < 3);
      total++;
      if ({EnemyX, EnemyY, EnemyXS, EnemyYS, reverse, alive, squished} !==
          {10'(m_x), 10'(m_y), 10'(SZ), 10'(m_ys), 1'(m_rev), 1'(m_alive), 1'(m_sq)}) begin
        bad++;
        if (errs < 10)
          $display("FAIL random_cyc%0d: X=%0d Y=%0d YS=%0d rev=%b alive=%b sq=%b want %0d %0d %0d %0d %0d %0d",
                   i, EnemyX, EnemyY, EnemyYS, reverse, alive, squished,
                   m_x, m_y, m_ys, m_rev, m_alive, m_sq);
        errs++;
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_patrol();
    test_clamp();
    test_wall();
    test_stomp();
    test_respawn();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
